// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Brief    : Shared constants, glyph table, FSM state type and pattern
//             classifier for the seven-segment reader.
//             SEG_READER_DP_EN widens the pattern to include the decimal
//             point line (bit 7).
//  Revision : 1.0  initial release
// ============================================================================
package seg_pkg;

    // Active-low pattern with every segment dark
    localparam logic [6:0] SEG_BLANK = 7'h7F;

`ifdef SEG_READER_DP_EN
    localparam int PAT_W = 8;
`else
    localparam int PAT_W = 7;
`endif

    // Active-low glyphs, bit0=a ... bit6=g, indexed by hex value
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [0:0] {
        TRACK   = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Returns {legal, code}; code is 0 when the pattern is not a glyph
    function automatic logic [4:0] seg_to_code(input logic [6:0] pat);
        logic [4:0] res;
        res = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (pat == SEG_GLYPH[i]) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : seg_debounce
//  Brief    : Multi-flop synchroniser followed by a saturating stability
//             counter. Emits a one-clock accept pulse when the synchronised
//             pattern has been identical for STABLE_CYCLES samples.
//  Revision : 1.0  initial release
// ============================================================================
module seg_debounce #(
    parameter int W             = 7,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] pat_i,
    output logic         accept_o,
    output logic [W-1:0] pat_o
);

    localparam int             CW    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  C_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  C_PRE = CW'(STABLE_CYCLES - 1);

    logic [W-1:0]  sync_q [SYNC_STAGES];
    logic [W-1:0]  prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          same;

    // Synchroniser chain; resets to the all-dark pattern
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            sync_q[0] <= pat_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Stability counter: clears on any change, saturates once stable
    always_comb begin
        same     = (sync_q[SYNC_STAGES-1] == prev_q);
        prev_d   = sync_q[SYNC_STAGES-1];
        cnt_d    = '0;
        accept_o = 1'b0;
        if (same) begin
            cnt_d    = (cnt_q == C_MAX) ? cnt_q : cnt_q + 1'b1;
            accept_o = (cnt_q == C_PRE);
        end
    end

    // Previous-sample and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '1;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pat_o = sync_q[SYNC_STAGES-1];

endmodule : seg_debounce
`default_nettype wire

// File: rtl/seven_seg_reader.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_reader
//  Brief    : Recovers the hex code shown on an active-low 7-segment bus.
//             Debounced patterns are classified (glyph / blank / illegal),
//             filtered so only changes are reported, and presented over a
//             valid/ready handshake with overrun indication on replacement.
//             Define SEG_READER_DP_EN to add the dp_n input and out_dp output.
//  Revision : 1.0  initial release
// ============================================================================
module seven_seg_reader
    import seg_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] seg_n,
`ifdef SEG_READER_DP_EN
    input  logic       dp_n,
    output logic       out_dp,
`endif
    output logic [3:0] out_code,
    output logic       out_blank,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun
);

    logic [PAT_W-1:0] pat_in;
    logic [PAT_W-1:0] pat;
    logic             accept;

`ifdef SEG_READER_DP_EN
    assign pat_in = {dp_n, seg_n};
`else
    assign pat_in = seg_n;
`endif

    seg_debounce #(
        .W             (PAT_W),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .pat_i    (pat_in),
        .accept_o (accept),
        .pat_o    (pat)
    );

    state_t           state_q, state_d;
    logic [PAT_W-1:0] last_q, last_d;
    logic [3:0]       code_q, code_d;
    logic             blank_q, blank_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic             change;
    logic [4:0]       cls;
    logic             is_blank;
    logic [3:0]       new_code;
    logic             new_err;

    // Classification of the debounced pattern and change detection
    always_comb begin
        cls      = seg_to_code(pat[6:0]);
        is_blank = (pat[6:0] == SEG_BLANK);
        new_code = cls[4] ? cls[3:0] : 4'h0;
        new_err  = !cls[4] && !is_blank;
        change   = accept && (pat != last_q);
    end

    // Handshake FSM: load on change, release on transfer, flag replacement
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        code_d    = code_q;
        blank_d   = blank_q;
        err_d     = err_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        case (state_q)
            TRACK: begin
                if (change) begin
                    state_d = PRESENT;
                    valid_d = 1'b1;
                end
            end
            PRESENT: begin
                if (change) begin
                    // Undelivered result lost only if not taken this clock
                    overrun_d = !out_ready;
                end else if (out_ready) begin
                    state_d = TRACK;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = TRACK;
                valid_d = 1'b0;
            end
        endcase
        if (change) begin
            last_d  = pat;
            code_d  = new_code;
            blank_d = is_blank;
            err_d   = new_err;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= TRACK;
            last_q    <= '1;
            code_q    <= 4'h0;
            blank_q   <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            code_q    <= code_d;
            blank_q   <= blank_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_code  = code_q;
    assign out_blank = blank_q;
    assign out_err   = err_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

`ifdef SEG_READER_DP_EN
    // DP line is bit 7 of the last reported pattern; cleared with the outputs
    assign out_dp = valid_q ? !last_q[7] : 1'b0;
`endif

endmodule : seven_seg_reader
`default_nettype wire

// File: tb/tb_seven_seg_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_reader
//  Brief    : Self-checking bench for seven_seg_reader. Stimulus pushes the
//             expected result into a queue; a monitor pops and compares on
//             every valid&ready transfer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_reader;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 16;

    // Active-low glyphs used below
    localparam logic [6:0] P_BLANK = 7'h7F;
    localparam logic [6:0] P_1     = 7'h79;
    localparam logic [6:0] P_3     = 7'h30;
    localparam logic [6:0] P_5     = 7'h12;
    localparam logic [6:0] P_7     = 7'h78;
    localparam logic [6:0] P_8     = 7'h00;
    localparam logic [6:0] P_A     = 7'h08;
    localparam logic [6:0] P_AG    = 7'h3E;   // a and g lit only: illegal

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] seg_n = P_BLANK;
    logic [3:0] out_code;
    logic       out_blank, out_err, out_valid, overrun;
    logic       out_ready = 1'b1;
    logic       dp_n = 1'b1;
    logic       out_dp;

    int n_vec  = 0;
    int n_fail = 0;
    int n_ovr  = 0;

    // Expected result: {dp, blank, err, code}
    logic [6:0] exp_q [$];

    always #5 clk = ~clk;

    seven_seg_reader #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seg_n     (seg_n),
`ifdef SEG_READER_DP_EN
        .dp_n      (dp_n),
        .out_dp    (out_dp),
`endif
        .out_code  (out_code),
        .out_blank (out_blank),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

`ifndef SEG_READER_DP_EN
    assign out_dp = 1'b0;
`endif

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every transfer against the scoreboard, count overruns
    always @(negedge clk) begin
        if (reset_n && overrun) n_ovr++;
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", int'({out_dp, out_blank, out_err, out_code}), -1);
            end else begin
                check("result", int'({out_dp, out_blank, out_err, out_code}), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic show(input logic [6:0] pat, input int cycles);
        @(posedge clk);
        #1 seg_n = pat;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        // Reset state
        #12;
        check("reset_valid", int'(out_valid), 0);
        check("reset_code", int'(out_code), 0);
        check("reset_flags", int'({out_blank, out_err, overrun}), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Blank at power-up stays silent
        repeat (30) @(posedge clk);
        #1;
        check("powerup_silent", int'(out_valid), 0);

        // Latency of glyph "3"
        exp_q.push_back({1'b0, 1'b0, 1'b0, 4'h3});
        @(posedge clk);
        #1 seg_n = P_3;
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid) break;
        end
        check("latency_3", n, SYNC_STAGES + 17);
        @(posedge clk);
        #1;
        check("one_beat_3", int'(out_valid), 0);

        // Glitch to "8" for 10 clocks, back to last reported "3"
        show(P_8, 10);
        show(P_3, 40);
        check("glitch_no_valid", int'(out_valid), 0);
        check("glitch_no_overrun", n_ovr, 0);

        // Blank -> A -> blank
        exp_q.push_back({1'b0, 1'b1, 1'b0, 4'h0});
        show(P_BLANK, 25);
        exp_q.push_back({1'b0, 1'b0, 1'b0, 4'hA});
        show(P_A, 25);
        exp_q.push_back({1'b0, 1'b1, 1'b0, 4'h0});
        show(P_BLANK, 25);

        // Illegal pattern
        exp_q.push_back({1'b0, 1'b0, 1'b1, 4'h0});
        show(P_AG, 25);

        // Replacement while stalled
        out_ready = 1'b0;
        show(P_1, 25);
        check("stall_valid", int'(out_valid), 1);
        check("stall_code_1", int'(out_code), 1);
        show(P_7, 25);
        check("replaced_code_7", int'(out_code), 7);
        check("overrun_once", n_ovr, 1);
        exp_q.push_back({1'b0, 1'b0, 1'b0, 4'h7});
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("taken_7", int'(out_valid), 0);

        // Reset while a result is pending
        out_ready = 1'b0;
        show(P_5, 25);
        check("pending_5", int'(out_valid), 1);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_outs", int'({out_valid, out_blank, out_err, out_code, overrun}), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 1'b0, 4'h5});
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;

`ifdef SEG_READER_DP_EN
        // Decimal point: "5" with DP lit, then DP off alone
        exp_q.push_back({1'b1, 1'b0, 1'b0, 4'h5});
        dp_n = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 1'b0, 1'b0, 4'h5});
        dp_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
`endif

        // Drain scoreboard with a bound
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        check("overrun_total", n_ovr, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_seven_seg_reader
`default_nettype wire
